// File: rtl/round_timer_ctrl.sv
// Round countdown controller: gates the ms tick generator while a round is
// running, folds ms ticks into whole seconds and pulses timeout at zero.
module round_timer_ctrl #(
  parameter int MS_PER_SEC = 1000,
  parameter int SEC_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             resume,
  input  logic             abort,
  input  logic [SEC_W-1:0] load_secs,
  input  logic             ms_tick,
  output logic             tick_en,
  output logic             tick_clr,
  output logic [SEC_W-1:0] secs_left,
  output logic             timeout,
  output logic             busy,
  output logic             paused
);

  localparam int MS_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
  localparam logic [MS_W-1:0]  MS_LAST = MS_W'(MS_PER_SEC - 1);
  localparam logic [MS_W-1:0]  MS_ONE  = MS_W'(1);
  localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
  logic             tick_en_q, tick_en_d;
  logic             tick_clr_q, tick_clr_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             paused_q, paused_d;

  // Seconds decrement that saturates at zero instead of wrapping.
  function automatic logic [SEC_W-1:0] sat_dec(input logic [SEC_W-1:0] v);
    return (v == '0) ? '0 : (v - SEC_ONE);
  endfunction

  // Next-state and next-output decode in command priority order.
  always_comb begin
    state_d    = state_q;
    secs_d     = secs_q;
    ms_cnt_d   = ms_cnt_q;
    tick_clr_d = 1'b0;
    timeout_d  = 1'b0;

    if (abort) begin
      state_d  = S_IDLE;
      secs_d   = '0;
      ms_cnt_d = '0;
    end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      ms_cnt_d = '0;
      if (load_secs != '0) begin
        state_d    = S_RUN;
        secs_d     = load_secs;
        tick_clr_d = 1'b1;
      end else begin
        state_d   = S_DONE;
        secs_d    = '0;
        timeout_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          // A tick arriving with pause is still counted; expiry beats pause.
          if (ms_tick) begin
            if (ms_cnt_q != MS_LAST) begin
              ms_cnt_d = ms_cnt_q + MS_ONE;
            end else begin
              ms_cnt_d = '0;
              secs_d   = sat_dec(secs_q);
              if (secs_q == SEC_ONE) begin
                state_d   = S_DONE;
                timeout_d = 1'b1;
              end
            end
          end
          if (pause && state_d == S_RUN) begin
            state_d = S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (resume) begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    tick_en_d = (state_d == S_RUN);
    busy_d    = (state_d == S_RUN) || (state_d == S_PAUSED);
    paused_d  = (state_d == S_PAUSED);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      secs_q     <= '0;
      ms_cnt_q   <= '0;
      tick_en_q  <= 1'b0;
      tick_clr_q <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      paused_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      secs_q     <= secs_d;
      ms_cnt_q   <= ms_cnt_d;
      tick_en_q  <= tick_en_d;
      tick_clr_q <= tick_clr_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      paused_q   <= paused_d;
    end
  end

  assign tick_en   = tick_en_q;
  assign tick_clr  = tick_clr_q;
  assign secs_left = secs_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;
  assign paused    = paused_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl with MS_PER_SEC=4: a driver pushes the
// hand-derived expected outputs per cycle, a monitor pops and compares them.
module tb_round_timer_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic       resume;
  logic       abort;
  logic [7:0] load_secs;
  logic       ms_tick;
  logic       tick_en;
  logic       tick_clr;
  logic [7:0] secs_left;
  logic       timeout;
  logic       busy;
  logic       paused;

  typedef struct {
    string      tag;
    logic       en;
    logic       clr;
    logic [7:0] secs;
    logic       to;
    logic       bz;
    logic       pz;
  } exp_t;

  exp_t  sb_q[$];
  string tag;
  int    n_tests;
  int    n_fail;

  round_timer_ctrl #(.MS_PER_SEC(4), .SEC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .resume    (resume),
    .abort     (abort),
    .load_secs (load_secs),
    .ms_tick   (ms_tick),
    .tick_en   (tick_en),
    .tick_clr  (tick_clr),
    .secs_left (secs_left),
    .timeout   (timeout),
    .busy      (busy),
    .paused    (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected right after the following rising edge.
  task automatic step(input logic rs, input logic st, input logic pa, input logic re,
                      input logic ab, input logic [7:0] ld, input logic tk,
                      input logic e_en, input logic e_clr, input logic [7:0] e_secs,
                      input logic e_to, input logic e_bz, input logic e_pz);
    exp_t e;
    @(negedge clk);
    rst = rs; start = st; pause = pa; resume = re; abort = ab;
    load_secs = ld; ms_tick = tk;
    e.tag = tag; e.en = e_en; e.clr = e_clr; e.secs = e_secs;
    e.to = e_to; e.bz = e_bz; e.pz = e_pz;
    sb_q.push_back(e);
  endtask

  // Monitor: compare every registered output just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_tests++;
      if (tick_en !== e.en || tick_clr !== e.clr || secs_left !== e.secs ||
          timeout !== e.to || busy !== e.bz || paused !== e.pz) begin
        n_fail++;
        $display("FAIL %s: got en=%b clr=%b secs=%0d to=%b busy=%b paused=%b, expected en=%b clr=%b secs=%0d to=%b busy=%b paused=%b",
                 e.tag, tick_en, tick_clr, secs_left, timeout, busy, paused,
                 e.en, e.clr, e.secs, e.to, e.bz, e.pz);
      end
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; pause = 1'b0; resume = 1'b0; abort = 1'b0;
    load_secs = 8'd0; ms_tick = 1'b0;
    n_tests = 0; n_fail = 0;

    // Reset with random command inputs: everything zero.
    tag = "reset";
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), 1'($urandom), 0, 0, 8'd0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0);
    tag = "idle_tick";
    step(0, 0, 0, 0, 0, 8'd0, 1, 0, 0, 8'd0, 0, 0, 0);

    // Three-second round, tick every cycle (tick in start cycle ignored).
    tag = "count3";
    step(0, 1, 0, 0, 0, 8'd3, 1, 1, 1, 8'd3, 0, 1, 0);
    for (int k = 1; k <= 11; k++)
      step(0, 0, 0, 0, 0, 8'd0, 1, 1, 0, 8'(3 - k / 4), 0, 1, 0);
    tag = "expire3";
    step(0, 0, 0, 0, 0, 8'd0, 1, 0, 0, 8'd0, 1, 0, 0);
    tag = "done_hold";
    step(0, 0, 0, 0, 0, 8'd0, 1, 0, 0, 8'd0, 0, 0, 0);

    // Pause with a tick in the same cycle, ignored ticks, resume.
    tag = "pause_start";
    step(0, 1, 0, 0, 0, 8'd3, 0, 1, 1, 8'd3, 0, 1, 0);
    for (int k = 1; k <= 5; k++)
      step(0, 0, 0, 0, 0, 8'd0, 1, 1, 0, 8'(3 - k / 4), 0, 1, 0);
    tag = "pause_tick";
    step(0, 0, 1, 0, 0, 8'd0, 1, 0, 0, 8'd2, 0, 1, 1);
    tag = "paused_ign";
    for (int k = 0; k < 10; k++)
      step(0, 0, 0, 0, 0, 8'd0, 1, 0, 0, 8'd2, 0, 1, 1);
    tag = "resume";
    step(0, 0, 0, 1, 0, 8'd0, 0, 1, 0, 8'd2, 0, 1, 0);
    tag = "after_resume";
    for (int k = 1; k <= 5; k++)
      step(0, 0, 0, 0, 0, 8'd0, 1, 1, 0, (k < 2) ? 8'd2 : 8'd1, 0, 1, 0);
    tag = "resume_expire";
    step(0, 0, 0, 0, 0, 8'd0, 1, 0, 0, 8'd0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0);

    // Zero-length round from DONE.
    tag = "load0";
    step(0, 1, 0, 0, 0, 8'd0, 1, 0, 0, 8'd0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 8'd0, 1, 0, 0, 8'd0, 0, 0, 0);

    // Abort mid-run, and abort together with start.
    tag = "abort";
    step(0, 1, 0, 0, 0, 8'd5, 1, 1, 1, 8'd5, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, 1, 1, 0, 8'd5, 0, 1, 0);
    step(0, 0, 0, 0, 1, 8'd0, 1, 0, 0, 8'd0, 0, 0, 0);
    tag = "abort_start";
    step(0, 1, 0, 0, 0, 8'd5, 0, 1, 1, 8'd5, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, 1, 1, 0, 8'd5, 0, 1, 0);
    step(0, 1, 0, 0, 1, 8'd7, 1, 0, 0, 8'd0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'd0, 1, 0, 0, 8'd0, 0, 0, 0);

    // Pause arriving with the final tick: expiry wins.
    tag = "pause_expire";
    step(0, 1, 0, 0, 0, 8'd1, 0, 1, 1, 8'd1, 0, 1, 0);
    for (int k = 0; k < 3; k++)
      step(0, 0, 0, 0, 0, 8'd0, 1, 1, 0, 8'd1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 8'd0, 1, 0, 0, 8'd0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0);

    // Pause and resume together; start ignored while paused.
    tag = "pr_both";
    step(0, 1, 0, 0, 0, 8'd2, 0, 1, 1, 8'd2, 0, 1, 0);
    step(0, 0, 1, 1, 0, 8'd0, 0, 0, 0, 8'd2, 0, 1, 1);
    tag = "start_paused";
    step(0, 1, 0, 0, 0, 8'd9, 0, 0, 0, 8'd2, 0, 1, 1);
    tag = "pr_both_resume";
    step(0, 0, 1, 1, 0, 8'd0, 0, 1, 0, 8'd2, 0, 1, 0);

    // Start ignored while running (its tick still counts), then reset mid-run.
    tag = "start_run";
    step(0, 0, 0, 0, 0, 8'd0, 1, 1, 0, 8'd2, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, 1, 1, 0, 8'd2, 0, 1, 0);
    step(0, 1, 0, 0, 0, 8'd9, 1, 1, 0, 8'd2, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'd0, 1, 1, 0, 8'd1, 0, 1, 0);
    tag = "rst_run";
    step(1, 0, 0, 0, 0, 8'd0, 1, 0, 0, 8'd0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 8'd0, 1, 0, 0, 8'd0, 0, 0, 0);

    // Let the monitor drain the queue.
    @(negedge clk);
    rst = 1'b0; start = 1'b0; pause = 1'b0; resume = 1'b0; abort = 1'b0;
    ms_tick = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
